uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver that deserialises an asynchronous serial line into parallel words, LSB first.
- It is the receive-side companion of the team's uart_tx. It uses the same clk_div and bits_per_word programming, so a tx/rx pair loops back with identical register values.
- It sits between the board RX pin and the bus register block. The register block reads words through a ready/acknowledge handshake.

Parameters:
- DATA_W, 16: width of data_out; maximum word length is DATA_W bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line; idle high
- clk_div  input  16  clock cycles per bit period; values below 4 unsupported; sampled at start-bit detect and held for the frame
- bits_per_word  input  5  word length minus one: 7 = 8 data bits, 15 = 16 data bits; values above DATA_W-1 unsupported; sampled at start-bit detect
- data_out  output  DATA_W  last received word; bits above bits_per_word are zero
- data_ready  output  1  high while an unacknowledged word is held in data_out
- rd_ack  input  1  one-cycle pulse from consumer; clears data_ready and overrun
- busy  output  1  high whenever state is not IDLE
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- overrun  output  1  sticky; set when a word completes while data_ready is already high

Behaviour:
- Synchroniser
  - rx passes through a 2-FF synchroniser (rx_s) before any use; adds 2 cycles of latency.
  - All timing below is relative to rx_s.
- Reset
  - Reset wins over all other activity, including mid-frame: state=IDLE, data_out=0, data_ready=0, frame_err=0, overrun=0, busy=0, bit counter=0, baud counter=0.
  - Synchroniser flops reset to 1.
- Baud counter
  - 16-bit; reloaded on every state entry.
  - Generates a sample tick after half = clk_div>>1 cycles in START, and after clk_div cycles in DATA and STOP.
- IDLE
  - On a rx_s 1->0 transition: latch clk_div and bits_per_word, clear the shift register, go to START.
  - A line held low after reset or after BREAK does not start a frame; a falling edge is required.
- START
  - At the half-bit tick, sample rx_s.
  - If 0: go to DATA with bit_pos=0.
  - If 1: glitch; return to IDLE with no outputs changed.
- DATA
  - At each clk_div tick, store rx_s into shift[bit_pos].
  - If bit_pos==latched bits_per_word: go to STOP; else bit_pos+1.
  - Samples therefore fall mid-bit.
- STOP, at its tick, sample rx_s:
  - If 1: data_out<=shift; data_ready<=1 on the next clock edge. If data_ready was already 1 and rd_ack is not asserted that cycle, also set overrun<=1. Newest word overwrites data_out. Go to IDLE.
  - If 0: pulse frame_err for 1 cycle; data_out and data_ready unchanged; go to BREAK.
- BREAK
  - Wait until rx_s==1, then go to IDLE.
  - Covers break conditions and line faults.
- Handshake
  - rd_ack while data_ready=1: data_ready<=0, overrun<=0.
  - rd_ack while data_ready=0: no effect except clearing overrun.
  - rd_ack in the same cycle as word completion: data_ready stays 1, new data loaded, overrun cleared/not set.
- busy = (state != IDLE), combinational from the state register.
- Latency
  - data_ready rises 1 cycle after the stop-bit sample.
  - The stop-bit sample occurs about 2 + half + (bits_per_word+2)*clk_div cycles after the rx pin falls.
- State encoding: IDLE, START, DATA, STOP, BREAK. Any illegal encoding returns to IDLE.

Test Plan:
1. Normal word: clk_div=16, bits_per_word=7, drive frame for 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_out=0x00A5, data_ready=1 one cycle after stop sample, frame_err=0, overrun=0; rd_ack pulse -> data_ready=0.
2. Full-width word:
   - Stimulus: clk_div=10, bits_per_word=15, send 0xBEEF.
   - Response: data_out=0xBEEF.
   - Back-to-back second frame 0x1234 with rd_ack between: data_out=0x1234, no overrun.
3. Glitch start: 3-cycle low pulse on rx with clk_div=16 -> busy high briefly, returns to IDLE, data_ready stays 0, no frame_err.
4. Framing error:
   - Stimulus: send 0x3C with stop bit 0, then hold rx low 50 cycles, then release.
   - Response: frame_err single-cycle pulse; data_out unchanged; busy stays high until rx returns high.
   - A following valid frame 0x55 is received correctly.
5. Overrun:
   - Stimulus: send 0x11 then 0x22 without rd_ack.
   - Response: data_out=0x22, overrun=1, data_ready=1; rd_ack clears both.
   - Repeat with rd_ack coincident with the second word's completion cycle: overrun stays 0.
6. Reset mid-frame and loopback:
   - Stimulus: assert rst during DATA bit 3.
   - Response: all outputs reset; next frame 0x5A received correctly.
   - Loopback: connect uart_tx.tx to rx with clk_div=8, bits_per_word=7, send 0x00, 0xFF, 0x81 -> received words match exactly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: LSB-first UART receiver with a 2-FF input synchroniser, programmable baud and word length, and a ready/ack handshake
module uart_rx #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   input  logic [15:0]       clk_div,
   input  logic [4:0]        bits_per_word,
   output logic [DATA_W-1:0] data_out,
   output logic              data_ready,
   input  logic              rd_ack,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);
   localparam int IW = $clog2(DATA_W);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   state_t            state;
   logic              rx_m, rx_s, rx_q;
   logic [15:0]       cnt, div_l;
   logic [4:0]        bpw_l, bit_pos;
   logic [DATA_W-1:0] shift;
   logic              tick;
   assign busy = state != IDLE;
   assign tick = cnt == ((state == START) ? {1'b0, div_l[15:1]} - 16'd1 : div_l - 16'd1);
   // Synchronise rx and keep its previous value for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_q <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_q <= rx_s;
      end
   end
   // Frame state machine, baud counter, shift register and handshake flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         div_l      <= '0;
         bpw_l      <= '0;
         bit_pos    <= '0;
         shift      <= '0;
         data_out   <= '0;
         data_ready <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         cnt       <= cnt + 16'd1;
         if (rd_ack) begin
            data_ready <= 1'b0;
            overrun    <= 1'b0;
         end
         case (state)
            IDLE: if (rx_q && !rx_s) begin
               div_l <= clk_div;
               bpw_l <= bits_per_word;
               shift <= '0;
               cnt   <= '0;
               state <= START;
            end
            START: if (tick) begin
               cnt     <= '0;
               bit_pos <= '0;
               state   <= rx_s ? IDLE : DATA;
            end
            DATA: if (tick) begin
               cnt                    <= '0;
               shift[bit_pos[IW-1:0]] <= rx_s;
               if (bit_pos == bpw_l) state <= STOP;
               else bit_pos <= bit_pos + 5'd1;
            end
            STOP: if (tick) begin
               cnt <= '0;
               if (rx_s) begin
                  data_out   <= shift;
                  data_ready <= 1'b1;
                  overrun    <= !rd_ack && (data_ready || overrun);
                  state      <= IDLE;
               end else begin
                  frame_err <= 1'b1;
                  state     <= BREAK;
               end
            end
            BREAK: if (rx_s) begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of uart_rx checked every cycle, plus directed literal checks
module tb_uart_rx;
   logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_ack = 1'b0;
   logic [15:0] clk_div = 16'd16;
   logic [4:0]  bits_per_word = 5'd7;
   logic [15:0] data_out;
   logic        data_ready, busy, frame_err, overrun;
   int          tests = 0, fails = 0, cyc = 0;
   typedef struct {int due; logic [15:0] word; bit good;} ev_t;
   ev_t         q[$];
   logic [15:0] m_do = '0;
   bit          m_dr = 0, m_ov = 0, m_fe = 0;

   uart_rx #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .rx(rx), .clk_div(clk_div), .bits_per_word(bits_per_word),
      .data_out(data_out), .data_ready(data_ready), .rd_ack(rd_ack), .busy(busy),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Model: each sent frame completes at its predicted stop-sample edge
   always @(posedge clk) begin
      cyc++;
      m_fe = 0;
      if (rst) begin
         q.delete();
         m_do = '0;
         m_dr = 0;
         m_ov = 0;
      end else if (q.size() > 0 && q[0].due == cyc) begin
         if (q[0].good) begin
            m_ov = !rd_ack && (m_dr || m_ov);
            m_do = q[0].word;
            m_dr = 1;
         end else begin
            m_fe = 1;
            if (rd_ack) begin m_dr = 0; m_ov = 0; end
         end
         void'(q.pop_front());
      end else if (rd_ack) begin
         m_dr = 0;
         m_ov = 0;
      end
   end

   // Compare DUT against the model away from the active edge
   always @(negedge clk) if (cyc > 1) begin
      tests++;
      if (data_out !== m_do || data_ready !== m_dr || overrun !== m_ov || frame_err !== m_fe) begin
         fails++;
         $display("FAIL model cyc=%0d got do=%h dr=%b ov=%b fe=%b want do=%h dr=%b ov=%b fe=%b",
                  cyc, data_out, data_ready, overrun, frame_err, m_do, m_dr, m_ov, m_fe);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] w, input int div, input int bpw, input bit stop_ok, input bit ack_at_done);
      int due;
      logic [31:0] mask;
      clk_div = 16'(div);
      bits_per_word = 5'(bpw);
      mask = (32'd1 << (bpw + 1)) - 32'd1;
      due = cyc + 3 + div / 2 + (bpw + 2) * div;
      q.push_back('{due, w & mask[15:0], stop_ok});
      rx = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i <= bpw; i++) begin
         rx = w[i];
         repeat (div) @(negedge clk);
      end
      rx = stop_ok;
      for (int i = 0; i < div; i++) begin
         rd_ack = ack_at_done && (cyc + 1 == due);
         @(negedge clk);
      end
      rd_ack = 1'b0;
   endtask

   task automatic ack();
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_do", data_out, 0);
      chk("reset_flags", {data_ready, busy, frame_err, overrun}, 4'b0000);
      repeat (4) @(negedge clk);
      // normal 8-bit word
      send(16'h00A5, 16, 7, 1, 0);
      chk("t1_do", data_out, 16'h00A5);
      chk("t1_model_do", m_do, 16'h00A5);
      chk("t1_ready", data_ready, 1);
      chk("t1_ov", overrun, 0);
      ack();
      chk("t1_ack", data_ready, 0);
      // full-width words with ack between
      send(16'hBEEF, 10, 15, 1, 0);
      chk("t2_do", data_out, 16'hBEEF);
      ack();
      send(16'h1234, 10, 15, 1, 0);
      chk("t2_do2", data_out, 16'h1234);
      chk("t2_ov", overrun, 0);
      ack();
      // glitch start
      clk_div = 16'd16;
      bits_per_word = 5'd7;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_busy", busy, 1);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("t3_idle", busy, 0);
      chk("t3_ready", data_ready, 0);
      // framing error then break
      send(16'h003C, 16, 7, 0, 0);
      repeat (50) @(negedge clk);
      chk("t4_busy_break", busy, 1);
      chk("t4_do_kept", data_out, 16'h1234);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      chk("t4_idle", busy, 0);
      send(16'h0055, 16, 7, 1, 0);
      chk("t4_do", data_out, 16'h0055);
      ack();
      // overrun and its clear
      send(16'h0011, 16, 7, 1, 0);
      send(16'h0022, 16, 7, 1, 0);
      chk("t5_do", data_out, 16'h0022);
      chk("t5_ov", {data_ready, overrun}, 2'b11);
      ack();
      chk("t5_clr", {data_ready, overrun}, 2'b00);
      // ack coincident with completion
      send(16'h0033, 16, 7, 1, 0);
      send(16'h0044, 16, 7, 1, 1);
      chk("t5_coinc", {data_ready, overrun}, 2'b10);
      chk("t5_coinc_do", data_out, 16'h0044);
      ack();
      // reset during data bit 3
      clk_div = 16'd16;
      bits_per_word = 5'd7;
      rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'(8'hA5 >> i);
         repeat (16) @(negedge clk);
      end
      rx = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_busy_mid", busy, 1);
      rst = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("t6_rst", {data_out, data_ready, busy, frame_err, overrun}, 20'h0);
      repeat (4) @(negedge clk);
      send(16'h005A, 16, 7, 1, 0);
      chk("t6_do", data_out, 16'h005A);
      ack();
      // transmitter-style loopback words
      send(16'h0000, 8, 7, 1, 0);
      chk("t6_lb0", {data_ready, data_out}, 17'h10000);
      ack();
      send(16'h00FF, 8, 7, 1, 0);
      chk("t6_lb1", data_out, 16'h00FF);
      ack();
      send(16'h0081, 8, 7, 1, 0);
      chk("t6_lb2", data_out, 16'h0081);
      ack();
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
